// File: rtl/uart_tx_stream_arbiter_if.sv
// Requester byte streams plus the naive_bus write port of the UART TX FIFO.
// master = arbiter side, slave = requesters/UART side.
interface uart_tx_stream_arbiter_if #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               m_wr_req;
  logic [3:0]         m_wr_be;
  logic [31:0]        m_wr_addr;
  logic [31:0]        m_wr_data;
  logic               m_wr_gnt;
  logic               busy;
  logic [PTR_W-1:0]   cur_owner;

  modport master (
    input  req_valid, req_data, m_wr_gnt,
    output req_ready, m_wr_req, m_wr_be, m_wr_addr, m_wr_data, busy, cur_owner
  );

  modport slave (
    output req_valid, req_data, m_wr_gnt,
    input  req_ready, m_wr_req, m_wr_be, m_wr_addr, m_wr_data, busy, cur_owner
  );
endinterface

// File: rtl/uart_tx_stream_arbiter.sv
// Round-robin, burst-granular sharing of the UART TX FIFO among N_REQ byte streams; one byte per 2 cycles max.
// Define TX_CHANNEL_TAG_EN to prefix each change of owner with the ASCII tag byte '0'+owner.
module uart_tx_stream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  localparam int PTR_W    = $clog2(N_REQ)
) (
  input logic                      clk,
  input logic                      rst_n,
  uart_tx_stream_arbiter_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifdef TX_CHANNEL_TAG_EN
  localparam logic [1:0] TAG   = 2'd1;
`endif
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam int               CW    = PTR_W + 1;
  localparam logic [CW-1:0]    N_W   = CW'(N_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);
  localparam logic [7:0]       MAX_B = 8'(MAX_BURST);

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [7:0]       burst_cnt;
  logic [7:0]       hold;
`ifdef TX_CHANNEL_TAG_EN
  logic [PTR_W-1:0] last_owner;
  logic             last_vld;
`endif

  logic [PTR_W-1:0] pick;
  logic [CW-1:0]    cand;
  logic             owner_vld;
  logic [7:0]       owner_dat;
  logic [7:0]       burst_nxt;
  logic             wr_phase;
  logic             release_now;
  logic [N_REQ-1:0] ready;

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (bus.req_valid[cand[PTR_W-1:0]]) pick = cand[PTR_W-1:0];
    end
  end

  assign owner_vld = bus.req_valid[owner];
  assign owner_dat = bus.req_data[{owner, 3'b000} +: 8];
  assign burst_nxt = burst_cnt + 8'd1;

`ifdef TX_CHANNEL_TAG_EN
  assign wr_phase = (state == WRITE) || (state == TAG);
`else
  assign wr_phase = (state == WRITE);
`endif

  // A grant ends on a dry stream, a newline, or an exhausted burst allowance.
  assign release_now = ((state == FETCH) && !owner_vld) ||
                       ((state == WRITE) && bus.m_wr_gnt &&
                        ((hold == 8'h0A) || (burst_nxt == MAX_B)));

  always_comb begin
    ready = '0;
    if (state == FETCH) ready[owner] = owner_vld;
  end

  assign bus.req_ready = ready;
  assign bus.m_wr_req  = wr_phase;
  assign bus.m_wr_be   = wr_phase ? 4'b0001 : 4'b0000;
  assign bus.m_wr_addr = 32'h0;
  assign bus.m_wr_data = wr_phase ? {24'h0, hold} : 32'h0;
  assign bus.busy      = (state != IDLE);
  assign bus.cur_owner = (state != IDLE) ? owner : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      hold      <= 8'h00;
`ifdef TX_CHANNEL_TAG_EN
      last_owner <= '0;
      last_vld   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            owner <= pick;
`ifdef TX_CHANNEL_TAG_EN
            if (!last_vld || (pick != last_owner)) begin
              state <= TAG;
              hold  <= 8'h30 + 8'(pick);
            end else begin
              state <= FETCH;
            end
`else
            state <= FETCH;
`endif
          end
        end
`ifdef TX_CHANNEL_TAG_EN
        TAG: if (bus.m_wr_gnt) state <= FETCH;
`endif
        FETCH: begin
          if (owner_vld) begin
            hold  <= owner_dat;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (bus.m_wr_gnt) begin
            burst_cnt <= burst_nxt;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      if (release_now) begin
        state     <= IDLE;
        rr_ptr    <= (owner == LAST) ? '0 : owner + 1'b1;
        burst_cnt <= '0;
`ifdef TX_CHANNEL_TAG_EN
        last_owner <= owner;
        last_vld   <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/uart_tx_stream_arbiter.md
Name: uart_tx_stream_arbiter

Overview:
Shares the single user UART TX FIFO (naive_bus slave, data register at address 0x0) between N_REQ independent byte-stream requesters, e.g. CPU console, debug monitor and DMA log.
- Round-robin arbitration at line/burst granularity.
- Writes one byte per naive_bus write transaction and obeys wr_gnt back-pressure when the FIFO is full.
- Sits between the requesters and the bus-side port of the UART TX slave.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8
MAX_BURST, 16, maximum bytes sent per grant before forced release; legal range 1..255
PTR_W, $clog2(N_REQ), owner index width (derived, not overridable)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester byte valid
req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  output  N_REQ  per-requester accept; combinational
m_wr_req  output  1  naive_bus write request
m_wr_be  output  4  write byte enables
m_wr_addr  output  32  write address
m_wr_data  output  32  write data
m_wr_gnt  input  1  write grant from the UART TX slave
busy  output  1  high whenever state != IDLE
cur_owner  output  PTR_W  index of the current grant holder; 0 when idle

Behaviour:
- Reset is clk/rst_n: asynchronous assert, active-low. Reset values:
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, hold=8'h00, last_owner=invalid.
  - Outputs: m_wr_req=0, m_wr_be=0, m_wr_addr=0, m_wr_data=0, req_ready=0, busy=0, cur_owner=0.
- Bus outputs are registered from state/hold. Exceptions: req_ready is combinational, and m_wr_be/m_wr_addr are constants while m_wr_req=1.
- FSM states: IDLE, TAG (optional), FETCH, WRITE.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning upward from rr_ptr with wrap; latch it into owner.
  - Next state is TAG if TX_CHANNEL_TAG_EN is defined and owner != last_owner; otherwise FETCH.
  - Otherwise stay in IDLE.
  - One cycle of arbitration latency from req_valid to entering FETCH/TAG.
- FETCH:
  - req_ready[owner] = req_valid[owner]; all other req_ready bits are 0.
  - On handshake: hold <= byte, go to WRITE.
  - If req_valid[owner]=0: release.
- WRITE:
  - m_wr_req=1, m_wr_addr=32'h0, m_wr_be=4'b0001, m_wr_data={24'h0,hold}.
  - These stay stable until m_wr_gnt; wait indefinitely while the FIFO is full (gnt low).
  - On gnt: burst_cnt <= burst_cnt+1.
    - If hold==8'h0A or burst_cnt+1==MAX_BURST: release.
    - Else return to FETCH.
- Release:
  - state <= IDLE, rr_ptr <= (owner==N_REQ-1) ? 0 : owner+1.
  - burst_cnt <= 0, last_owner <= owner.
- Throughput: one byte per 2 cycles maximum (FETCH+WRITE).
- Fairness: a requester holding valid high continuously is served at most MAX_BURST bytes before every other pending requester gets a turn.
- The bus handshake exists only in WRITE/TAG: m_wr_req is never asserted in IDLE or FETCH.
- Reset mid-WRITE: the held byte is dropped (it was already accepted from the requester), and m_wr_req deasserts immediately.
- A grant arriving in the same cycle a requester drops valid is unaffected; valid is sampled only in FETCH.
- burst_cnt is 8 bits and never wraps, because it is cleared at MAX_BURST.

Optional Feature:
TX_CHANNEL_TAG_EN
- Defined:
  - On a grant whose owner differs from last_owner, TAG state writes one byte 8'h30+owner (ASCII '0'..'7') using the WRITE handshake rules, then enters FETCH.
  - The tag byte does not count toward burst_cnt.
  - last_owner resets to invalid, so the first grant after reset is always tagged.
- Undefined: TAG state is absent, and IDLE goes directly to FETCH.

Test Plan:
- Single requester: req 0 sends "AB\n", gnt always 1 -> exactly 3 writes, m_wr_data 0x41,0x42,0x0A, each one cycle; release after 0x0A; busy low 1 cycle later.
- Round-robin: reqs 1 and 3 both hold valid with continuous non-newline data, MAX_BURST=4 -> owner sequence 1,3,1,3; each grant makes exactly 4 writes; rr_ptr after the first release = 2.
- Back-pressure: gnt held low 20 cycles during WRITE -> m_wr_req/m_wr_data stable all 20 cycles; no req_ready pulse; exactly one write completes when gnt rises.
- Valid drop: req 2 sends 2 bytes then deasserts valid -> release in FETCH after 2 writes; next owner is the next pending index above 2, with wrap.
- Reset mid-WRITE: assert rst_n low while m_wr_req=1 -> all outputs 0 asynchronously; after release, idle with cur_owner=0.
- TX_CHANNEL_TAG_EN: req 1 sends "x\n", then req 1 again, then req 2 -> bytes 0x31,'x',0x0A, then no tag for the repeat, then 0x32 before req 2's data.
